cascadable_counter: RTL and testbench

//   Parametrised loadable up/down counter slice with cascade carry-in/out, modulus

---
 rtl/counter_pkg.sv | 41 ++++
 rtl/cascadable_counter.sv | 85 ++++++++
 tb/tb_cascadable_counter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// ============================================================================
// Module      : counter_pkg
// Description : Shared types and next-count helper for cascadable_counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } count_mode_e;

    // Arithmetic is carried at a fixed 32-bit width; callers keep the low WIDTH bits.
    localparam int C_CALC_W = 32;

    typedef struct packed {
        logic [C_CALC_W-1:0] next;
        logic                term;
    } next_count_t;

    function automatic next_count_t next_count(
        input logic [C_CALC_W-1:0] cnt,
        input logic                up,
        input logic [C_CALC_W-1:0] modulus,
        input count_mode_e         mode
    );
        next_count_t res;
        res.term = up ? (cnt == modulus - 1) : (cnt == '0);
        if (up) begin
            res.next = res.term ? ((mode == CNT_SAT) ? cnt : '0) : cnt + 1;
        end else begin
            res.next = res.term ? ((mode == CNT_SAT) ? cnt : modulus - 1) : cnt - 1;
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cascadable_counter.sv
// ============================================================================
// Module      : cascadable_counter
// Description : Loadable up/down counter slice with cascade carry, wrap or
//               saturate at the modulus, registered compare and sticky overflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cascadable_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = 8,    // 2..31
    parameter int MODULUS = 256,  // 2..2**WIDTH
    parameter int SAT     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             cin,
    input  logic             up,
    input  logic [WIDTH-1:0] cmp_val,
    output logic [WIDTH-1:0] cnt,
    output logic             cout,
    output logic             match,
    output logic             ovf
);

    localparam count_mode_e      C_MODE = (SAT != 0) ? CNT_SAT : CNT_WRAP;
    localparam logic [WIDTH-1:0] C_MAX  = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_cnt;
    logic             r_match;
    logic             r_ovf;

    next_count_t      w_step;
    logic             w_count;
    logic             w_load_clamp;
    logic [WIDTH-1:0] w_cnt_next;
    logic             w_ovf_next;
    logic             w_unused_hi;

    assign w_step       = next_count(C_CALC_W'(r_cnt), up, C_CALC_W'(MODULUS), C_MODE);
    assign w_count      = en & cin;
    assign w_load_clamp = (C_CALC_W'(load_val) >= C_CALC_W'(MODULUS));
    assign w_unused_hi  = ^w_step.next[C_CALC_W-1:WIDTH];

    always_comb begin
        w_cnt_next = r_cnt;
        w_ovf_next = r_ovf;
        if (clr) begin
            w_cnt_next = '0;
            w_ovf_next = 1'b0;
        end else if (load) begin
            w_cnt_next = w_load_clamp ? C_MAX : load_val;
        end else if (w_count) begin
            w_cnt_next = w_step.next[WIDTH-1:0];
            w_ovf_next = r_ovf | w_step.term;
        end
    end

    // Compare against the value being registered so match lines up with cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_match <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_next;
            r_match <= (w_cnt_next == cmp_val);
            r_ovf   <= w_ovf_next;
        end
    end

    // In saturate mode cout still fires at the terminal count; ovf flags the hold.
    assign cout  = w_count & ~clr & ~load & w_step.term;
    assign cnt   = r_cnt;
    assign match = r_match;
    assign ovf   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_cascadable_counter.sv
// ============================================================================
// Module      : tb_cascadable_counter
// Description : Directed scoreboard bench for cascadable_counter slices.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cascadable_counter;

    logic       clk = 1'b0;
    logic       rst_n, clr, load, en, cin, up;
    logic [7:0] load_val, cmp_val;

    logic [7:0] c8;
    logic       cout8, m8, o8;
    logic [3:0] cw, cs, clo, chi;
    logic       coutw, mw, ow, couts, ms, os, lo_cout, hi_cout, mlo, olo, mhi, ohi;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    cascadable_counter #(.WIDTH(8), .MODULUS(256), .SAT(0)) u8 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .cin(cin), .up(up), .cmp_val(cmp_val),
        .cnt(c8), .cout(cout8), .match(m8), .ovf(o8));

    cascadable_counter #(.WIDTH(4), .MODULUS(10), .SAT(0)) u10w (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val[3:0]),
        .en(en), .cin(cin), .up(up), .cmp_val(cmp_val[3:0]),
        .cnt(cw), .cout(coutw), .match(mw), .ovf(ow));

    cascadable_counter #(.WIDTH(4), .MODULUS(10), .SAT(1)) u10s (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val[3:0]),
        .en(en), .cin(cin), .up(up), .cmp_val(cmp_val[3:0]),
        .cnt(cs), .cout(couts), .match(ms), .ovf(os));

    cascadable_counter #(.WIDTH(4), .MODULUS(16), .SAT(0)) u_lo (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val[3:0]),
        .en(en), .cin(cin), .up(up), .cmp_val(cmp_val[3:0]),
        .cnt(clo), .cout(lo_cout), .match(mlo), .ovf(olo));

    cascadable_counter #(.WIDTH(4), .MODULUS(16), .SAT(0)) u_hi (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val[7:4]),
        .en(en), .cin(lo_cout), .up(up), .cmp_val(cmp_val[7:4]),
        .cnt(chi), .cout(hi_cout), .match(mhi), .ovf(ohi));

    task automatic exp_push(input string tag, input logic [7:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [7:0] obs);
        exp_t e;
        tests++;
        if (sb.size() == 0) begin
            failed++;
            $error("FAIL scoreboard_empty: observed %0h expected <none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                failed++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; clr = 1'b0; load = 1'b0; en = 1'b0; cin = 1'b1; up = 1'b1;
        load_val = 8'h00; cmp_val = 8'h00;
        tick(); tick();
        exp_push("rst_cnt", 8'h00); exp_push("rst_match", 8'h0); exp_push("rst_ovf", 8'h0);
        check(c8); check(8'(m8)); check(8'(o8));
        rst_n = 1'b1;

        // Full-range wrap, then reach 0x37 with ovf and match set.
        load = 1'b1; load_val = 8'hFF; tick();
        load = 1'b0; en = 1'b1;
        exp_push("full_wrap_cnt", 8'h00); exp_push("full_wrap_ovf", 8'h1);
        tick(); check(c8); check(8'(o8));
        load = 1'b1; load_val = 8'h36; en = 1'b0; tick();
        load = 1'b0; en = 1'b1; cmp_val = 8'h37;
        exp_push("pre_rst_cnt", 8'h37); exp_push("pre_rst_match", 8'h1); exp_push("pre_rst_ovf", 8'h1);
        tick(); check(c8); check(8'(m8)); check(8'(o8));
        en = 1'b0;
        #2 rst_n = 1'b0;
        exp_push("async_rst_cnt", 8'h00); exp_push("async_rst_match", 8'h0); exp_push("async_rst_ovf", 8'h0);
        #1 check(c8); check(8'(m8)); check(8'(o8));
        #1 rst_n = 1'b1;

        // Wrap up, modulus 10.
        load = 1'b1; load_val = 8'h07; tick();
        load = 1'b0; en = 1'b1; cin = 1'b1; up = 1'b1;
        exp_push("wrap_cnt7", 8'h07); exp_push("wrap_cout7", 8'h0);
        #1 check(8'(cw)); check(8'(coutw));
        exp_push("wrap_cnt8", 8'h08); exp_push("wrap_cout8", 8'h0); exp_push("wrap_ovf8", 8'h0);
        tick(); check(8'(cw)); check(8'(coutw)); check(8'(ow));
        exp_push("wrap_cnt9", 8'h09); exp_push("wrap_cout9", 8'h1);
        tick(); check(8'(cw)); check(8'(coutw));
        exp_push("wrap_cnt0", 8'h00); exp_push("wrap_cout0", 8'h0); exp_push("wrap_ovf0", 8'h1);
        tick(); check(8'(cw)); check(8'(coutw)); check(8'(ow));
        exp_push("wrap_cnt1", 8'h01); exp_push("wrap_ovf1", 8'h1);
        tick(); check(8'(cw)); check(8'(ow));

        // Saturate down, modulus 10.
        en = 1'b0; clr = 1'b1;
        exp_push("clr_cnt", 8'h00); exp_push("clr_ovf", 8'h0);
        tick(); check(8'(cs)); check(8'(os));
        clr = 1'b0; load = 1'b1; load_val = 8'h02;
        exp_push("sat_load2", 8'h02);
        tick(); check(8'(cs));
        load = 1'b0; en = 1'b1; up = 1'b0;
        exp_push("sat_cnt1", 8'h01); exp_push("sat_ovf1", 8'h0);
        tick(); check(8'(cs)); check(8'(os));
        exp_push("sat_cnt0", 8'h00); exp_push("sat_ovf0", 8'h0); exp_push("sat_cout0", 8'h1);
        tick(); check(8'(cs)); check(8'(os)); check(8'(couts));
        exp_push("sat_hold_cnt", 8'h00); exp_push("sat_hold_ovf", 8'h1); exp_push("sat_hold_cout", 8'h1);
        tick(); check(8'(cs)); check(8'(os)); check(8'(couts));
        exp_push("sat_hold2_cnt", 8'h00);
        tick(); check(8'(cs));

        // Priority and load clamp on the wrap slice (ovf set from wrapping 0->9 above).
        en = 1'b0; load = 1'b1; load_val = 8'h05;
        exp_push("prio_load5", 8'h05); exp_push("prio_ovf_kept", 8'h1);
        tick(); check(8'(cw)); check(8'(ow));
        clr = 1'b1; load = 1'b1; en = 1'b1; load_val = 8'h03;
        exp_push("prio_clr_cnt", 8'h00); exp_push("prio_clr_ovf", 8'h0);
        tick(); check(8'(cw)); check(8'(ow));
        clr = 1'b0; load = 1'b1; load_val = 8'h0C; up = 1'b1;
        exp_push("clamp_cnt", 8'h09); exp_push("load_blocks_cout", 8'h0);
        tick(); check(8'(cw)); check(8'(coutw));
        load = 1'b0;
        exp_push("term_cout", 8'h1);
        #1 check(8'(coutw));

        // Two-slice cascade.
        en = 1'b0; load = 1'b1; load_val = 8'h0F; tick();
        load = 1'b0; en = 1'b1; up = 1'b1; cin = 1'b1;
        exp_push("casc_lo_cout", 8'h1);
        #1 check(8'(lo_cout));
        exp_push("casc_0x10", 8'h10); exp_push("casc_lo_cout_off", 8'h0);
        tick(); check({chi, clo}); check(8'(lo_cout));
        exp_push("casc_hi_hold", 8'h11);
        tick(); check({chi, clo});

        // Compare.
        en = 1'b0; clr = 1'b1; tick();
        clr = 1'b0; load = 1'b1; load_val = 8'h01; cmp_val = 8'h03;
        exp_push("cmp_cnt1", 8'h01); exp_push("cmp_m1", 8'h0);
        tick(); check(c8); check(8'(m8));
        load = 1'b0; en = 1'b1; up = 1'b1;
        exp_push("cmp_m2", 8'h0);
        tick(); check(8'(m8));
        exp_push("cmp_cnt3", 8'h03); exp_push("cmp_m3", 8'h1);
        tick(); check(c8); check(8'(m8));
        exp_push("cmp_m4", 8'h0);
        tick(); check(8'(m8));
        en = 1'b0; cmp_val = 8'h04;
        exp_push("cmp_no_comb", 8'h0);
        #1 check(8'(m8));
        exp_push("cmp_next_edge", 8'h1); exp_push("cmp_hold_cnt", 8'h04);
        tick(); check(8'(m8)); check(c8);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
